// File: rtl/rr_onehot_arbiter.sv
// rtl/rr_onehot_arbiter.sv - round-robin arbiter with registered one-hot grant held until ack
// Optional grant watchdog enabled by defining RR_ARB_GRANT_TIMEOUT_EN.
module rr_onehot_arbiter #(
  parameter int NUM_REQ        = 8,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int IW            = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               ack,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   gnt_d;
  logic [IW-1:0]        idx_d;
  logic                 valid_d;
  logic                 expire;
  logic                 release_now;
  logic                 new_grant;
  logic [IW-1:0]        next_ptr;
  logic [IW-1:0]        base;
  logic                 found;
  logic [IW-1:0]        win_idx;

  // On release the scan starts just past the outgoing winner, giving it lowest priority.
  always_comb begin
    release_now = (state_q == GRANT) && (ack || expire);
    next_ptr    = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);
    base        = release_now ? next_ptr : ptr_q;
    found       = 1'b0;
    win_idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = int'(base) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[j]) begin
        found   = 1'b1;
        win_idx = IW'(j);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt;
    idx_d     = gnt_idx;
    valid_d   = gnt_valid;
    new_grant = 1'b0;
    if ((state_q == IDLE) || release_now) begin
      if (release_now) ptr_d = next_ptr;
      gnt_d   = '0;
      idx_d   = '0;
      valid_d = 1'b0;
      state_d = IDLE;
      if (found) begin
        gnt_d[win_idx] = 1'b1;
        idx_d          = win_idx;
        valid_d        = 1'b1;
        state_d        = GRANT;
        new_grant      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt       <= gnt_d;
      gnt_idx   <= idx_d;
      gnt_valid <= valid_d;
    end
  end

`ifdef RR_ARB_GRANT_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WDW-1:0] wd_q;

  // Expiry fires on the grant's TIMEOUT_CYCLES-th cycle; a concurrent ack takes precedence.
  assign expire = (state_q == GRANT) && !ack && (wd_q == WDW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q    <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= expire;
      if (new_grant || state_q != GRANT) wd_q <= '0;
      else                               wd_q <= wd_q + WDW'(1);
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES ^ new_grant;
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule
